secded_decodificador_pipe: RTL

Pipelined, parametrised Hamming SECDED decoder: the clocked successor of the 4-bit/8-bit combinational encode/decode top. It accepts a received codeword of any supported data width over a valid/ready handshake. It returns the corrected data, the error classification and the error bit position two cycles later. It also keeps saturating counts of single and double errors for the LED and display front end.

---
 rtl/secded_pkg.sv | 42 ++++
 rtl/secded_sindrome.sv | 27 ++
 rtl/secded_decodificador_pipe.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/secded_pkg.sv
// Shared definitions for the Hamming SECDED codec: parity-width sizing,
// codeword position to data index mapping and the error classification.
package secded_pkg;

    typedef enum logic [1:0] {
        SIN_ERROR = 2'd0,
        SIMPLE    = 2'd1,
        DOBLE     = 2'd2
    } err_class_e;

    // Smallest p with 2^p >= data_w + p + 1 (data_w up to 57 needs p = 6).
    function automatic int calc_par_w(input int data_w);
        int res;
        res = 7;
        for (int p = 7; p >= 1; p--) begin
            if ((1 << p) >= data_w + p + 1) begin
                res = p;
            end
        end
        return res;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Data index held at Hamming position pos; -1 for parity positions.
    function automatic int pos_to_idx(input int pos);
        int n_par;
        n_par = 0;
        if (pos <= 0 || is_pow2(pos)) begin
            return -1;
        end
        for (int b = 0; b < 7; b++) begin
            if ((1 << b) < pos) begin
                n_par++;
            end
        end
        return pos - n_par - 1;
    endfunction

endpackage

// File: rtl/secded_sindrome.sv
// Combinational syndrome and overall-parity generator for a SECDED codeword;
// shared between the decoder pipeline and the matching encoder.
module secded_sindrome
    import secded_pkg::*;
#(
    parameter  int DATA_W = 4,
    localparam int PAR_W  = calc_par_w(DATA_W),
    localparam int CW_W   = DATA_W + PAR_W + 1
) (
    input  logic [CW_W-1:0]  codeword,
    output logic [PAR_W-1:0] sindrome,
    output logic             paridad
);

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        sindrome = '0;
        for (int p = 1; p < CW_W; p++) begin
            if (codeword[p]) begin
                sindrome = sindrome ^ PAR_W'(p);
            end
        end
        paridad = ^codeword;
    end

endmodule

// File: rtl/secded_decodificador_pipe.sv
// Two-stage SECDED decoder with valid/ready handshake and saturating
// single/double error counters for the display front end.
module secded_decodificador_pipe
    import secded_pkg::*;
#(
    parameter  int DATA_W = 4,
    parameter  int CNT_W  = 8,
    localparam int PAR_W  = calc_par_w(DATA_W),
    localparam int CW_W   = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW_W-1:0]   palabra_rx,
    input  logic              valid_in,
    output logic              ready_in,
    output logic [DATA_W-1:0] dato_corr,
    output logic              error_simple,
    output logic              error_doble,
    output logic [PAR_W-1:0]  pos_error,
    output logic              valid_out,
    input  logic              ready_out,
    input  logic              clear_cnt,
    output logic [CNT_W-1:0]  cnt_simple,
    output logic [CNT_W-1:0]  cnt_doble
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAR_W-1:0]  sind_rx;
    logic              par_rx;
    logic [DATA_W-1:0] dato_rx;

    logic              s1_valid_d,  s1_valid_q;
    logic [DATA_W-1:0] s1_dato_d,   s1_dato_q;
    logic [PAR_W-1:0]  s1_sind_d,   s1_sind_q;
    logic              s1_par_d,    s1_par_q;

    logic              valid_out_d,    valid_out_q;
    logic [DATA_W-1:0] dato_corr_d,    dato_corr_q;
    logic              error_simple_d, error_simple_q;
    logic              error_doble_d,  error_doble_q;
    logic [PAR_W-1:0]  pos_error_d,    pos_error_q;
    logic [CNT_W-1:0]  cnt_simple_d,   cnt_simple_q;
    logic [CNT_W-1:0]  cnt_doble_d,    cnt_doble_q;

    logic              en;
    logic              handshake;
    logic              flip;
    err_class_e        clase;
    logic [DATA_W-1:0] dato_fix;

    secded_sindrome #(.DATA_W(DATA_W)) u_sindrome (
        .codeword (palabra_rx),
        .sindrome (sind_rx),
        .paridad  (par_rx)
    );

    // Stage 1 keeps only the data field; parity bits are folded into S and P.
    always_comb begin
        dato_rx = '0;
        for (int p = 3; p < CW_W; p++) begin
            if (!is_pow2(p)) begin
                dato_rx[pos_to_idx(p)] = palabra_rx[p];
            end
        end
    end

    always_comb begin
        clase = SIN_ERROR;
        flip  = 1'b0;
        if (s1_par_q) begin
            if (s1_sind_q == '0) begin
                clase = SIMPLE;
            end else if (int'(s1_sind_q) >= CW_W) begin
                clase = DOBLE;
            end else begin
                clase = SIMPLE;
                flip  = 1'b1;
            end
        end else if (s1_sind_q != '0) begin
            clase = DOBLE;
        end

        dato_fix = s1_dato_q;
        for (int p = 3; p < CW_W; p++) begin
            if (!is_pow2(p) && flip && (s1_sind_q == PAR_W'(p))) begin
                dato_fix[pos_to_idx(p)] = ~s1_dato_q[pos_to_idx(p)];
            end
        end
    end

    assign en        = !valid_out_q || ready_out;
    assign handshake = valid_out_q && ready_out;

    always_comb begin
        s1_valid_d     = s1_valid_q;
        s1_dato_d      = s1_dato_q;
        s1_sind_d      = s1_sind_q;
        s1_par_d       = s1_par_q;
        valid_out_d    = valid_out_q;
        dato_corr_d    = dato_corr_q;
        error_simple_d = error_simple_q;
        error_doble_d  = error_doble_q;
        pos_error_d    = pos_error_q;

        if (en) begin
            s1_valid_d     = valid_in;
            s1_dato_d      = dato_rx;
            s1_sind_d      = sind_rx;
            s1_par_d       = par_rx;
            valid_out_d    = s1_valid_q;
            dato_corr_d    = dato_fix;
            error_simple_d = s1_valid_q && (clase == SIMPLE);
            error_doble_d  = s1_valid_q && (clase == DOBLE);
            pos_error_d    = s1_sind_q;
        end
    end

    // Clear has priority over a simultaneous increment.
    always_comb begin
        cnt_simple_d = cnt_simple_q;
        cnt_doble_d  = cnt_doble_q;
        if (clear_cnt) begin
            cnt_simple_d = '0;
            cnt_doble_d  = '0;
        end else if (handshake) begin
            if (error_simple_q && cnt_simple_q != CNT_MAX) begin
                cnt_simple_d = cnt_simple_q + 1'b1;
            end
            if (error_doble_q && cnt_doble_q != CNT_MAX) begin
                cnt_doble_d = cnt_doble_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_dato_q      <= '0;
            s1_sind_q      <= '0;
            s1_par_q       <= 1'b0;
            valid_out_q    <= 1'b0;
            dato_corr_q    <= '0;
            error_simple_q <= 1'b0;
            error_doble_q  <= 1'b0;
            pos_error_q    <= '0;
            cnt_simple_q   <= '0;
            cnt_doble_q    <= '0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_dato_q      <= s1_dato_d;
            s1_sind_q      <= s1_sind_d;
            s1_par_q       <= s1_par_d;
            valid_out_q    <= valid_out_d;
            dato_corr_q    <= dato_corr_d;
            error_simple_q <= error_simple_d;
            error_doble_q  <= error_doble_d;
            pos_error_q    <= pos_error_d;
            cnt_simple_q   <= cnt_simple_d;
            cnt_doble_q    <= cnt_doble_d;
        end
    end

    assign ready_in     = en;
    assign valid_out    = valid_out_q;
    assign dato_corr    = dato_corr_q;
    assign error_simple = error_simple_q;
    assign error_doble  = error_doble_q;
    assign pos_error    = pos_error_q;
    assign cnt_simple   = cnt_simple_q;
    assign cnt_doble    = cnt_doble_q;

endmodule
